// File: rtl/uart_rx_autobaud.sv
// ---------------------------------------------------------------------------
// uart_rx_autobaud
//
// Auto-baud controller placed in front of a UART receiver. It watches the raw
// serial line for a 0x55 sync character, measures the span of its first eight
// bit times, and drives the receiver's clocks-per-bit input with the rounded
// result. Receiver bytes are forwarded to the terminal logic only while a rate
// is locked (state RUN).
//
// Ports:
//   i_Clock         system clock
//   i_Reset_n       asynchronous, active-low reset
//   i_RX_Serial     raw serial line (synchronized internally)
//   i_Start         recalibration request, honoured only in RUN
//   i_RX_DV         byte-valid strobe from the UART receiver
//   i_RX_Byte       byte from the UART receiver
//   o_Clks_Per_Bit  bit-period configuration to the UART receiver
//   o_Locked        a valid rate is in force and bytes are forwarded
//   o_Busy          calibration in progress (any state other than RUN)
//   o_Cal_Done      one-cycle pulse when a calibration completes
//   o_Cal_Err       one-cycle pulse when a calibration is aborted
//   o_Byte_DV       forwarded byte-valid strobe (one cycle after i_RX_DV)
//   o_Byte          forwarded byte, held between strobes
// ---------------------------------------------------------------------------
module uart_rx_autobaud #(
  parameter int unsigned DEFAULT_CPB = 217,
  parameter int unsigned MIN_CPB     = 8,
  parameter int unsigned MAX_CPB     = 4095,   // must be <= 8191
  parameter int unsigned IDLE_CLKS   = 4096,
  parameter bit          AUTO_START  = 1'b1
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_RX_Serial,
  input  logic        i_Start,
  input  logic        i_RX_DV,
  input  logic [7:0]  i_RX_Byte,
  output logic [15:0] o_Clks_Per_Bit,
  output logic        o_Locked,
  output logic        o_Busy,
  output logic        o_Cal_Done,
  output logic        o_Cal_Err,
  output logic        o_Byte_DV,
  output logic [7:0]  o_Byte
);

  typedef enum logic [2:0] {
    HUNT_IDLE,
    HUNT_EDGE,
    MEASURE,
    SETTLE,
    RUN
  } state_t;

  localparam state_t RESET_STATE = AUTO_START ? HUNT_IDLE : RUN;

  localparam int unsigned IDLE_W = $clog2(IDLE_CLKS + 1);

  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CLKS - 1);
  localparam logic [12:0]       MIN_SEG   = 13'(MIN_CPB);
  localparam logic [12:0]       MAX_SEG   = 13'(MAX_CPB);
  localparam logic [15:0]       MIN_RATE  = 16'(MIN_CPB);
  localparam logic [15:0]       MAX_RATE  = 16'(MAX_CPB);
  localparam logic [15:0]       DEF_RATE  = 16'(DEFAULT_CPB);

  state_t              state;
  logic                sync1, sync2, rx_prev;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [12:0]         seg_cnt;
  logic [18:0]         total;
  logic [3:0]          edge_cnt;
  logic [19:0]         settle_cnt;
  logic [19:0]         settle_thresh;

  logic                rx_sync, edge_any, edge_fall;
  logic [12:0]         seg_len;
  logic [15:0]         cpb_new, cpb_max;
  logic [19:0]         thresh_new;
  logic                meas_abort, meas_done;

  // Edges are taken between the synchronized line and its one-cycle-old copy,
  // so every edge sees the same pipeline delay and segment lengths are exact.
  assign rx_sync   = sync2;
  assign edge_any  = rx_sync ^ rx_prev;
  assign edge_fall = rx_prev & ~rx_sync;

  // seg_cnt lags the true segment length by one clock on the cycle of the edge.
  assign seg_len = seg_cnt + 13'd1;

  // total+1 is the eight-bit span; adding 4 before the divide rounds to nearest.
  assign cpb_new    = 16'((total + 19'd5) >> 3);
  assign cpb_max    = (cpb_new > o_Clks_Per_Bit) ? cpb_new : o_Clks_Per_Bit;
  assign thresh_new = 20'(cpb_max) * 20'd11;

  // NOTE: every signal driven here gets a default first so no path can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    meas_abort = 1'b0;
    meas_done  = 1'b0;
    if (edge_any) begin
      if (seg_len < MIN_SEG) begin
        meas_abort = 1'b1;
      end else if (edge_cnt == 4'd7) begin
        if (cpb_new >= MIN_RATE && cpb_new <= MAX_RATE) meas_done  = 1'b1;
        else                                             meas_abort = 1'b1;
      end
    end else if (seg_len >= MAX_SEG) begin
      // The segment can no longer end within MAX_CPB clocks.
      meas_abort = 1'b1;
    end
  end

  assign o_Locked = (state == RUN);
  assign o_Busy   = (state != RUN);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      // NOTE: the counters and the byte register are reset as well as the
      // control state; the block is small and a clean restart discards any
      // half-finished measurement.
      state          <= RESET_STATE;
      sync1          <= 1'b1;
      sync2          <= 1'b1;
      rx_prev        <= 1'b1;
      idle_cnt       <= '0;
      seg_cnt        <= '0;
      total          <= '0;
      edge_cnt       <= '0;
      settle_cnt     <= '0;
      settle_thresh  <= '0;
      o_Clks_Per_Bit <= DEF_RATE;
      o_Cal_Done     <= 1'b0;
      o_Cal_Err      <= 1'b0;
      o_Byte_DV      <= 1'b0;
      o_Byte         <= '0;
    end else begin
      sync1      <= i_RX_Serial;
      sync2      <= sync1;
      rx_prev    <= sync2;
      o_Cal_Done <= 1'b0;
      o_Cal_Err  <= 1'b0;
      o_Byte_DV  <= 1'b0;

      case (state)
        HUNT_IDLE: begin
          if (!rx_sync) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            idle_cnt <= '0;
            state    <= HUNT_EDGE;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end

        HUNT_EDGE: begin
          if (edge_fall) begin
            seg_cnt  <= '0;
            total    <= '0;
            edge_cnt <= '0;
            state    <= MEASURE;
          end
        end

        MEASURE: begin
          if (meas_abort) begin
            o_Cal_Err <= 1'b1;
            idle_cnt  <= '0;
            state     <= HUNT_IDLE;
          end else if (meas_done) begin
            o_Clks_Per_Bit <= cpb_new;
            settle_thresh  <= thresh_new;
            settle_cnt     <= '0;
            state          <= SETTLE;
          end else begin
            total <= total + 19'd1;
            if (edge_any) begin
              seg_cnt  <= '0;
              edge_cnt <= edge_cnt + 4'd1;
            end else begin
              seg_cnt <= seg_cnt + 13'd1;
            end
          end
        end

        // The receiver is still chewing on the sync frame at the old rate;
        // wait for a long quiet stretch and drop whatever it strobes meanwhile.
        SETTLE: begin
          if (!rx_sync) begin
            settle_cnt <= '0;
          end else if (settle_cnt + 20'd1 == settle_thresh) begin
            o_Cal_Done <= 1'b1;
            state      <= RUN;
          end else begin
            settle_cnt <= settle_cnt + 20'd1;
          end
        end

        RUN: begin
          o_Byte_DV <= i_RX_DV;
          if (i_RX_DV) o_Byte <= i_RX_Byte;
          if (i_Start) begin
            idle_cnt <= '0;
            state    <= HUNT_IDLE;
          end
        end

        default: state <= RESET_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_autobaud.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_autobaud
//
// Drives sync frames as lists of edge-to-edge segment lengths and predicts the
// outcome from the segment list alone: any segment outside [MIN,MAX] aborts,
// otherwise the rate is round((sum)/8) and the settle wait is 11*max(old,new)
// high clocks. All stimulus changes on the falling clock edge; outputs are
// sampled on the falling edge too.
// ---------------------------------------------------------------------------
module tb_uart_rx_autobaud;

  localparam int MIN_CPB     = 4;
  localparam int MAX_CPB     = 100;
  localparam int IDLE_CLKS   = 64;
  localparam int DEFAULT_CPB = 20;
  // Input pin to FSM decision is two synchronizer flops plus the FSM flop.
  localparam int PIPE        = 3;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        rx      = 1'b1;
  logic        start   = 1'b0;
  logic        rx_dv   = 1'b0;
  logic [7:0]  rx_byte = 8'h00;

  logic [15:0] clks_per_bit;
  logic        locked, busy, cal_done, cal_err, byte_dv;
  logic [7:0]  byte_out;

  uart_rx_autobaud #(
    .DEFAULT_CPB (DEFAULT_CPB),
    .MIN_CPB     (MIN_CPB),
    .MAX_CPB     (MAX_CPB),
    .IDLE_CLKS   (IDLE_CLKS),
    .AUTO_START  (1'b1)
  ) dut (
    .i_Clock        (clk),
    .i_Reset_n      (rst_n),
    .i_RX_Serial    (rx),
    .i_Start        (start),
    .i_RX_DV        (rx_dv),
    .i_RX_Byte      (rx_byte),
    .o_Clks_Per_Bit (clks_per_bit),
    .o_Locked       (locked),
    .o_Busy         (busy),
    .o_Cal_Done     (cal_done),
    .o_Cal_Err      (cal_err),
    .o_Byte_DV      (byte_dv),
    .o_Byte         (byte_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Event log, updated only by tick() so there is a single writer.
  int cyc    = 0;
  int n_done = 0;
  int n_err  = 0;
  int n_bdv  = 0;
  int n_both = 0;
  int t_done = 0;
  int t_err  = 0;

  // Reference state: rate in force and whether the block should be in RUN.
  int model_cpb = DEFAULT_CPB;
  bit model_run = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cal_done) begin n_done++; t_done = cyc; end
    if (cal_err)  begin n_err++;  t_err  = cyc; end
    if (cal_done && cal_err) n_both++;
    if (byte_dv) n_bdv++;
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) tick();
  endtask

  function automatic void predict(input int segs[8], input int cur,
                                  output bit ok, output int cpb, output int thr);
    int sum;
    sum = 0;
    ok  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (segs[i] < MIN_CPB || segs[i] > MAX_CPB) ok = 1'b0;
      sum += segs[i];
    end
    cpb = (sum + 4) / 8;
    if (cpb < MIN_CPB || cpb > MAX_CPB) ok = 1'b0;
    if (!ok) cpb = cur;
    thr = 11 * ((cpb > cur) ? cpb : cur);
  endfunction

  task automatic leave_run();
    if (model_run) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
  endtask

  // One calibration attempt: idle, eight segments, a 12-clock low bit 7 with a
  // receiver strobe inside it, then the line returns high.
  task automatic attempt(input string tag, input int segs[8]);
    bit ok;
    int cpb, thr, d0, e0, b0, t_rise, k;
    predict(segs, model_cpb, ok, cpb, thr);
    leave_run();
    hold(1'b1, IDLE_CLKS + 16);
    d0 = n_done;
    e0 = n_err;
    b0 = n_bdv;
    for (int i = 0; i < 8; i++) hold((i % 2) ? 1'b1 : 1'b0, segs[i]);
    hold(1'b0, PIPE);
    if (ok) check({tag, "_cpb_at_edge8"}, 32'(clks_per_bit), cpb);
    rx_dv   = 1'b1;
    rx_byte = 8'h99;
    tick();
    rx_dv   = 1'b0;
    repeat (8) tick();
    rx     = 1'b1;
    t_rise = cyc;
    k      = 0;
    while (n_done == d0 && n_err == e0 && k < 11 * MAX_CPB + 40) begin
      tick();
      k++;
    end
    check({tag, "_done_cnt"}, n_done - d0, ok ? 1 : 0);
    check({tag, "_err_cnt"},  n_err - e0,  ok ? 0 : 1);
    check({tag, "_cpb"},      32'(clks_per_bit), cpb);
    check({tag, "_no_fwd"},   n_bdv - b0, 0);
    if (ok) begin
      check({tag, "_settle_clks"}, t_done - t_rise, thr + PIPE - 1);
      tick();
      check({tag, "_locked"}, 32'(locked), 1);
      check({tag, "_busy"},   32'(busy),   0);
    end else begin
      check({tag, "_busy"},   32'(busy),   1);
      check({tag, "_locked"}, 32'(locked), 0);
    end
    model_cpb = cpb;
    model_run = ok;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of test, expected finish within budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int segs[8];
    int d0, e0, t_fall, base, idx;

    // Reset state.
    repeat (3) tick();
    check("rst_cpb",    32'(clks_per_bit), DEFAULT_CPB);
    check("rst_locked", 32'(locked),   0);
    check("rst_busy",   32'(busy),     1);
    check("rst_done",   32'(cal_done), 0);
    check("rst_err",    32'(cal_err),  0);
    check("rst_bdv",    32'(byte_dv),  0);
    check("rst_byte",   32'(byte_out), 0);
    rst_n = 1'b1;
    tick();

    // Clean 0x55 at 16 clk/bit.
    segs = '{16, 16, 16, 16, 16, 16, 16, 16};
    attempt("sync16", segs);

    // Rounding: span 100 -> 12.5 rounds to 13.
    segs = '{12, 13, 12, 13, 12, 13, 12, 13};
    attempt("round13", segs);

    // 2-clock high glitch inside the start bit.
    segs = '{5, 2, 9, 16, 16, 16, 16, 16};
    attempt("glitch", segs);

    // Shortest legal segments.
    segs = '{4, 4, 4, 4, 4, 4, 4, 4};
    attempt("min_seg", segs);

    // One segment one clock too short.
    segs = '{16, 16, 3, 16, 16, 16, 16, 16};
    attempt("short_seg", segs);

    // Timeout: line held low well past MAX_CPB after the start edge.
    leave_run();
    hold(1'b1, IDLE_CLKS + 16);
    d0     = n_done;
    e0     = n_err;
    t_fall = cyc;
    hold(1'b0, MAX_CPB + 10);
    hold(1'b1, 5);
    check("timeout_err_cnt",  n_err - e0, 1);
    check("timeout_err_time", t_err - t_fall, MAX_CPB + PIPE);
    check("timeout_no_done",  n_done - d0, 0);
    check("timeout_cpb",      32'(clks_per_bit), model_cpb);
    model_run = 1'b0;

    // Longest legal segments.
    segs = '{100, 100, 100, 100, 100, 100, 100, 100};
    attempt("max_seg", segs);

    // Forwarding in RUN.
    rx_byte = 8'h41;
    rx_dv   = 1'b1;
    tick();
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    check("fwd_dv",        32'(byte_dv),  1);
    check("fwd_byte",      32'(byte_out), 32'h41);
    tick();
    check("fwd_dv_clear",  32'(byte_dv),  0);
    check("fwd_byte_hold", 32'(byte_out), 32'h41);

    // Randomized frames, some with an illegal short segment.
    for (int n = 0; n < 8; n++) begin
      base = int'($urandom_range(5, 30));
      for (int i = 0; i < 8; i++) segs[i] = base - 1 + int'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        idx       = int'($urandom_range(0, 7));
        segs[idx] = int'($urandom_range(1, 3));
      end
      attempt($sformatf("rand%0d", n), segs);
    end

    // Lock at a rate other than the default before exercising reset.
    segs = '{13, 13, 13, 13, 13, 13, 13, 13};
    attempt("relock13", segs);

    // i_Start in RUN with a byte strobed in the same cycle.
    rx_byte = 8'h5A;
    rx_dv   = 1'b1;
    start   = 1'b1;
    tick();
    rx_dv   = 1'b0;
    start   = 1'b0;
    check("start_locked", 32'(locked),   0);
    check("start_busy",   32'(busy),     1);
    check("start_fwd_dv", 32'(byte_dv),  1);
    check("start_fwd_b",  32'(byte_out), 32'h5A);
    model_run = 1'b0;

    // Reset asserted in the middle of a measurement.
    hold(1'b1, IDLE_CLKS + 16);
    hold(1'b0, 20);
    rst_n = 1'b0;
    #1;
    check("midrst_cpb",    32'(clks_per_bit), DEFAULT_CPB);
    check("midrst_locked", 32'(locked),   0);
    check("midrst_busy",   32'(busy),     1);
    check("midrst_done",   32'(cal_done), 0);
    check("midrst_err",    32'(cal_err),  0);
    check("midrst_bdv",    32'(byte_dv),  0);
    check("midrst_byte",   32'(byte_out), 0);
    rx = 1'b1;
    tick();
    rst_n     = 1'b1;
    model_cpb = DEFAULT_CPB;
    model_run = 1'b0;

    // Clean calibration after reset: settle wait is 11*max(20,16) = 220.
    segs = '{16, 16, 16, 16, 16, 16, 16, 16};
    attempt("post_rst16", segs);

    check("done_err_exclusive", n_both, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
